multicycle_controller: RTL and testbench

Sequencing FSM for a multicycle RV32I datapath. A single shared memory serves both instruction fetch and data access, and a single ALU serves PC increment, address calculation and execute. The block decodes the 7-bit opcode over several cycles and drives per-cycle enables and mux selects. It waits on a memory-ready handshake with a bounded timeout and raises a sticky trap on an illegal opcode or a memory timeout.

---
 rtl/rv32_ctrl_pkg.sv | 58 +++++
 rtl/mc_wait_timer.sv | 28 ++
 rtl/multicycle_controller.sv | 171 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I controller.
// State, opcode and datapath select encodings live here.
package rv32_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    ALU_WB   = 4'd4,
    MEM_ADDR = 4'd5,
    MEM_RD   = 4'd6,
    MEM_WB   = 4'd7,
    MEM_WR   = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] RES_ALU   = 2'b00;
  localparam logic [1:0] RES_MDR   = 2'b01;
  localparam logic [1:0] RES_PC    = 2'b10;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  // Opcode to first post-decode state; anything unknown traps.
  function automatic state_t decode_next(input logic [6:0] op);
    state_t s;
    unique case (op)
      OP_R:      s = EXEC_R;
      OP_I:      s = EXEC_I;
      OP_LOAD:   s = MEM_ADDR;
      OP_STORE:  s = MEM_ADDR;
      OP_BRANCH: s = BRANCH;
      OP_JAL:    s = JAL;
      default:   s = TRAP;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait counter for the multicycle controller.
// Counts stalled cycles and flags the last permitted one.
module mc_wait_timer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TIMER_W     = 5
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic limit
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(MEM_TIMEOUT - 1);

  logic [TIMER_W-1:0] count;

  // Clear wins; otherwise count stalled cycles, saturating at the limit.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en && !limit) begin
      count <= count + 1'b1;
    end
  end

  assign limit = (count == LAST);

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for a multicycle RV32I datapath.
// Shared memory and ALU, bounded memory waits, sticky trap.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TIMER_W     = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] Opcode,
  input  logic [2:0] Funct3,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       PCSrc,
  output logic       trap,
  output logic [3:0] state_o
);

  import rv32_ctrl_pkg::*;

  state_t state;
  logic   waiting;
  logic   stall;
  logic   hold;
  logic   tmo;
  logic   tmr_clr;
  logic   br_take;
  logic   pc_we;
  logic   ir_we;
  logic   rf_we;
  logic   mem_we;

  assign waiting = (state == FETCH) ||
                   (state == MEM_RD) ||
                   (state == MEM_WR);
  assign stall   = waiting && !mem_ready;
  assign hold    = (state == TRAP) || (stall && !tmo);
  assign tmr_clr = reset || !hold;

  mc_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TIMER_W     (TIMER_W)
  ) u_timer (
    .clk   (clk),
    .clr   (tmr_clr),
    .en    (stall),
    .limit (tmo)
  );

  // State register and next-state sequencing.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      unique case (state)
        FETCH:
          if (mem_ready)  state <= DECODE;
          else if (tmo)   state <= TRAP;
        DECODE:   state <= decode_next(Opcode);
        EXEC_R:   state <= ALU_WB;
        EXEC_I:   state <= ALU_WB;
        ALU_WB:   state <= FETCH;
        MEM_ADDR:
          state <= (Opcode == OP_LOAD) ? MEM_RD : MEM_WR;
        MEM_RD:
          if (mem_ready)  state <= MEM_WB;
          else if (tmo)   state <= TRAP;
        MEM_WB:   state <= FETCH;
        MEM_WR:
          if (mem_ready)  state <= FETCH;
          else if (tmo)   state <= TRAP;
        BRANCH:   state <= FETCH;
        JAL:      state <= FETCH;
        TRAP:     state <= TRAP;
        default:  state <= TRAP;
      endcase
    end
  end

  // Branch condition from funct3 and the ALU zero flag.
  always_comb begin
    br_take = 1'b0;
    unique case (1'b1)
      (Funct3 == F3_BEQ): br_take = Zero;
      (Funct3 == F3_BNE): br_take = !Zero;
      default:            br_take = 1'b0;
    endcase
  end

  // Per-state datapath controls.
  always_comb begin
    pc_we     = 1'b0;
    ir_we     = 1'b0;
    rf_we     = 1'b0;
    mem_we    = 1'b0;
    MemRead   = 1'b0;
    IorD      = 1'b0;
    ResultSrc = RES_ALU;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_RS2;
    ALUOp     = ALUOP_ADD;
    PCSrc     = 1'b0;
    trap      = 1'b0;
    unique case (state)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        pc_we   = mem_ready;
        ir_we   = mem_ready;
      end
      DECODE: ALUSrcB = SRCB_IMM;
      EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_R;
      end
      EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_I;
      end
      ALU_WB: rf_we = 1'b1;
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEM_WB: begin
        rf_we     = 1'b1;
        ResultSrc = RES_MDR;
      end
      MEM_WR: begin
        mem_we = 1'b1;
        IorD   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_SUB;
        PCSrc   = 1'b1;
        pc_we   = br_take;
      end
      JAL: begin
        rf_we     = 1'b1;
        ResultSrc = RES_PC;
        pc_we     = 1'b1;
        PCSrc     = 1'b1;
      end
      TRAP: trap = 1'b1;
      default: trap = 1'b1;
    endcase
  end

  // No architectural writes while reset is held.
  assign PCWrite  = pc_we  && !reset;
  assign IRWrite  = ir_we  && !reset;
  assign RegWrite = rf_we  && !reset;
  assign MemWrite = mem_we && !reset;
  assign state_o  = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller.
// Per-cycle expected outputs go through a scoreboard queue.
module tb_multicycle_controller;

  import rv32_ctrl_pkg::state_t;
  import rv32_ctrl_pkg::FETCH;
  import rv32_ctrl_pkg::DECODE;
  import rv32_ctrl_pkg::EXEC_R;
  import rv32_ctrl_pkg::EXEC_I;
  import rv32_ctrl_pkg::ALU_WB;
  import rv32_ctrl_pkg::MEM_ADDR;
  import rv32_ctrl_pkg::MEM_RD;
  import rv32_ctrl_pkg::MEM_WB;
  import rv32_ctrl_pkg::MEM_WR;
  import rv32_ctrl_pkg::BRANCH;
  import rv32_ctrl_pkg::JAL;
  import rv32_ctrl_pkg::TRAP;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] Opcode;
  logic [2:0] Funct3;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite, IRWrite, MemRead, MemWrite;
  logic       IorD, RegWrite, ALUSrcA, PCSrc, trap;
  logic [1:0] ResultSrc, ALUSrcB, ALUOp;
  logic [3:0] state_o;
  logic [18:0] obs;

  int checks = 0;
  int errors = 0;
  logic [18:0] sbq[$];

  multicycle_controller #(.MEM_TIMEOUT(16), .TIMER_W(5)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct3(Funct3),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite),
    .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .IorD(IorD), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSrc(PCSrc), .trap(trap), .state_o(state_o)
  );

  always #5 clk = ~clk;

  assign obs = {state_o, PCWrite, IRWrite, MemRead, MemWrite, IorD,
                RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp,
                PCSrc, trap};

  // Reference control table written from the state descriptions.
  function automatic logic [18:0] model(input state_t s, input logic mr,
                                        input logic z,
                                        input logic [2:0] f3,
                                        input logic rst);
    logic pcw, irw, mrd, mwr, iord, rw, sa, pcs, tr;
    logic [1:0] rs, sb, op;
    {pcw, irw, mrd, mwr, iord, rw, sa, pcs, tr} = '0;
    rs = 2'b00; sb = 2'b00; op = 2'b00;
    case (s)
      FETCH:    begin mrd = 1; sb = 2'b01; pcw = mr; irw = mr; end
      DECODE:   sb = 2'b10;
      EXEC_R:   begin sa = 1; op = 2'b10; end
      EXEC_I:   begin sa = 1; sb = 2'b10; op = 2'b11; end
      ALU_WB:   rw = 1;
      MEM_ADDR: begin sa = 1; sb = 2'b10; end
      MEM_RD:   begin mrd = 1; iord = 1; end
      MEM_WB:   begin rw = 1; rs = 2'b01; end
      MEM_WR:   begin mwr = 1; iord = 1; end
      BRANCH: begin
        sa = 1; op = 2'b01; pcs = 1;
        if (f3 == 3'b000) pcw = z;
        else if (f3 == 3'b001) pcw = !z;
      end
      JAL:      begin rw = 1; rs = 2'b10; pcw = 1; pcs = 1; end
      TRAP:     tr = 1;
      default:  tr = 1;
    endcase
    if (rst) begin pcw = 0; irw = 0; rw = 0; mwr = 0; end
    return {4'(s), pcw, irw, mrd, mwr, iord, rw, rs, sa, sb, op, pcs, tr};
  endfunction

  // Drive one cycle's inputs and queue the outputs that cycle should show.
  task automatic drive(input state_t es, input logic mr, input logic rst);
    @(negedge clk);
    mem_ready = mr;
    reset     = rst;
    sbq.push_back(model(es, mr, Zero, Funct3, rst));
    #1;
  endtask

  task automatic test_reset();
    logic [18:0] e;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    drive(FETCH, 1'b1, 1'b1);
    e = sbq.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_cycle: got %h expected %h", obs, e);
    end
    checks++;
    if (dut.u_timer.count !== 5'd0) begin
      errors++;
      $display("FAIL reset_timer: got %0d expected 0", dut.u_timer.count);
    end
  endtask

  task automatic test_rtype();
    state_t s[4] = '{FETCH, DECODE, EXEC_R, ALU_WB};
    logic [18:0] e;
    Opcode = 7'b0110011;
    foreach (s[i]) begin
      drive(s[i], 1'b1, 1'b0);
      e = sbq.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL rtype[%0d]: got %h expected %h", i, obs, e);
      end
    end
  endtask

  task automatic test_load_wait();
    state_t s[8] = '{FETCH, DECODE, MEM_ADDR, MEM_RD,
                     MEM_RD, MEM_RD, MEM_RD, MEM_WB};
    logic m[8] = '{1, 1, 1, 0, 0, 0, 1, 1};
    logic [18:0] e;
    Opcode = 7'b0000011;
    foreach (s[i]) begin
      drive(s[i], m[i], 1'b0);
      e = sbq.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL load[%0d]: got %h expected %h", i, obs, e);
      end
    end
  endtask

  task automatic test_store();
    state_t s[4] = '{FETCH, DECODE, MEM_ADDR, MEM_WR};
    logic [18:0] e;
    Opcode = 7'b0100011;
    foreach (s[i]) begin
      drive(s[i], 1'b1, 1'b0);
      e = sbq.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL store[%0d]: got %h expected %h", i, obs, e);
      end
    end
  endtask

  task automatic test_branch();
    state_t s[3] = '{FETCH, DECODE, BRANCH};
    logic [2:0] f3s[5] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b100};
    logic zs[5] = '{1, 0, 1, 0, 1};
    logic [18:0] e;
    Opcode = 7'b1100011;
    foreach (f3s[k]) begin
      Funct3 = f3s[k];
      Zero   = zs[k];
      foreach (s[i]) begin
        drive(s[i], 1'b1, 1'b0);
        e = sbq.pop_front();
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL branch[%0d.%0d]: got %h expected %h",
                   k, i, obs, e);
        end
      end
    end
  endtask

  task automatic test_jal();
    state_t s[3] = '{FETCH, DECODE, JAL};
    logic [18:0] e;
    Opcode = 7'b1101111;
    foreach (s[i]) begin
      drive(s[i], 1'b1, 1'b0);
      e = sbq.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL jal[%0d]: got %h expected %h", i, obs, e);
      end
    end
  endtask

  task automatic test_ready_at_limit();
    state_t s[$];
    logic m[$];
    logic [18:0] e;
    Opcode = 7'b0010011;
    for (int i = 0; i < 15; i++) begin
      s.push_back(FETCH); m.push_back(1'b0);
    end
    s.push_back(FETCH);  m.push_back(1'b1);
    s.push_back(DECODE); m.push_back(1'b0);
    s.push_back(EXEC_I); m.push_back(1'b0);
    s.push_back(ALU_WB); m.push_back(1'b0);
    foreach (s[i]) begin
      drive(s[i], m[i], 1'b0);
      e = sbq.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL limit_ready[%0d]: got %h expected %h", i, obs, e);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    state_t s[6] = '{FETCH, DECODE, MEM_ADDR, MEM_WR, MEM_WR, MEM_WR};
    logic m[6] = '{1, 1, 1, 0, 0, 0};
    logic r[6] = '{0, 0, 0, 0, 0, 1};
    logic [18:0] e;
    Opcode = 7'b0100011;
    foreach (s[i]) begin
      drive(s[i], m[i], r[i]);
      e = sbq.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL rst_wr[%0d]: got %h expected %h", i, obs, e);
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (state_o !== 4'(FETCH) || MemWrite !== 1'b0) begin
      errors++;
      $display("FAIL rst_wr_after: got state %0d memwrite %b expected %0d 0",
               state_o, MemWrite, 4'(FETCH));
    end
    checks++;
    if (dut.u_timer.count !== 5'd0) begin
      errors++;
      $display("FAIL rst_wr_timer: got %0d expected 0", dut.u_timer.count);
    end
  endtask

  task automatic test_fetch_timeout();
    state_t s[$];
    logic m[$];
    logic r[$];
    logic [18:0] e;
    for (int i = 0; i < 16; i++) begin
      s.push_back(FETCH); m.push_back(1'b0); r.push_back(1'b0);
    end
    for (int i = 0; i < 20; i++) begin
      s.push_back(TRAP);
      m.push_back(1'($urandom_range(0, 1)));
      r.push_back(1'b0);
    end
    s.push_back(TRAP);  m.push_back(1'b1); r.push_back(1'b1);
    s.push_back(FETCH); m.push_back(1'b0); r.push_back(1'b0);
    foreach (s[i]) begin
      Zero   = 1'($urandom_range(0, 1));
      Funct3 = 3'($urandom_range(0, 7));
      drive(s[i], m[i], r[i]);
      e = sbq.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL fetch_tmo[%0d]: got %h expected %h", i, obs, e);
      end
    end
  endtask

  task automatic test_illegal();
    state_t s[$];
    logic m[$];
    logic r[$];
    logic [18:0] e;
    s.push_back(FETCH);  m.push_back(1'b1); r.push_back(1'b0);
    s.push_back(DECODE); m.push_back(1'b1); r.push_back(1'b0);
    for (int i = 0; i < 20; i++) begin
      s.push_back(TRAP);
      m.push_back(1'($urandom_range(0, 1)));
      r.push_back(1'b0);
    end
    s.push_back(TRAP);  m.push_back(1'b0); r.push_back(1'b1);
    s.push_back(FETCH); m.push_back(1'b0); r.push_back(1'b0);
    foreach (s[i]) begin
      Opcode = (i == 0) ? 7'b1111111 : 7'($urandom_range(0, 127));
      if (i == 1) Opcode = 7'b1111111;
      drive(s[i], m[i], r[i]);
      e = sbq.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL illegal[%0d]: got %h expected %h", i, obs, e);
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    Opcode    = 7'b0110011;
    Funct3    = 3'b000;
    Zero      = 1'b0;
    mem_ready = 1'b0;
    test_reset();
    test_rtype();
    test_load_wait();
    test_store();
    test_branch();
    test_jal();
    test_ready_at_limit();
    test_reset_mid_write();
    test_fetch_timeout();
    test_illegal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
